// File: rtl/pico_irq_arbiter.sv
// Four-source edge-triggered interrupt arbiter with a round-robin grant and a port-mapped control/status block.
// Interrupt rises two edges after a source event; rd_data is registered one cycle after port_id is presented.
module pico_irq_arbiter #(
    parameter logic [7:0] PORT_CAUSE   = 8'h01,
    parameter logic [7:0] PORT_STATUS  = 8'h02,
    parameter logic [7:0] PORT_MASK_RD = 8'h03,
    parameter logic [7:0] PORT_MASK_WR = 8'h81,
    parameter logic [7:0] PORT_EOI     = 8'h82,
    parameter logic [7:0] PORT_OVR_CLR = 8'h83
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] src_in,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    input  logic       interrupt_ack,
    output logic       interrupt,
    output logic [7:0] rd_data
);

    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

    state_t     state_q, state_d;
    logic [3:0] src_prev_q, src_prev_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] overrun_q, overrun_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       interrupt_q, interrupt_d;

    logic [3:0] evt;
    logic [3:0] req;
    logic [3:0] clr;
    logic [3:0] ovr_clr_bits;
    logic [1:0] rr_win;
    logic [1:0] idx;
    logic       found;
    logic       mask_wr;
    logic       eoi_wr;
    logic       ovr_clr_wr;
    logic       unused_hi;

    assign unused_hi  = ^out_port[7:4];
    assign mask_wr    = write_strobe && (port_id == PORT_MASK_WR);
    assign eoi_wr     = write_strobe && (port_id == PORT_EOI);
    assign ovr_clr_wr = write_strobe && (port_id == PORT_OVR_CLR);

    // First requesting source at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        req    = pending_q & mask_q;
        rr_win = rr_ptr_q;
        idx    = rr_ptr_q;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!found && req[idx]) begin
                rr_win = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        clr      = 4'h0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ASSERT;
                    grant_d = rr_win;
                end
            end
            ASSERT: begin
                if (interrupt_ack) begin
                    state_d = SERVICE;
                    clr     = 4'b0001 << grant_q;
                end
            end
            SERVICE: begin
                if (eoi_wr) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        evt          = src_in & ~src_prev_q;
        src_prev_d   = src_in;
        ovr_clr_bits = ovr_clr_wr ? out_port[3:0] : 4'h0;
        // A new event beats both the acknowledge clear and the overrun clear.
        pending_d    = (pending_q & ~clr) | evt;
        overrun_d    = (overrun_q & ~ovr_clr_bits) | (evt & pending_q & ~clr);
        mask_d       = mask_wr ? out_port[3:0] : mask_q;
        interrupt_d  = (state_d == ASSERT);

        rd_data_d = 8'h00;
        if (port_id == PORT_CAUSE)
            rd_data_d = {(state_q == SERVICE), 5'b0, grant_q};
        else if (port_id == PORT_STATUS)
            rd_data_d = {overrun_q, pending_q};
        else if (port_id == PORT_MASK_RD)
            rd_data_d = {4'b0, mask_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            src_prev_q  <= 4'hF;
            pending_q   <= 4'h0;
            overrun_q   <= 4'h0;
            mask_q      <= 4'h0;
            grant_q     <= 2'd0;
            rr_ptr_q    <= 2'd0;
            rd_data_q   <= 8'h00;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_prev_q  <= src_prev_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            mask_q      <= mask_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            rd_data_q   <= rd_data_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign interrupt = interrupt_q;
    assign rd_data   = rd_data_q;

endmodule
